// File: rtl/tt_sweep_pkg.sv
// tt_sweep_pkg: shared states, sizes and golden-table lookup for the truth-table sweeper.
package tt_sweep_pkg;
   typedef enum logic [1:0] {IDLE, SETTLE, REPORT, DONE} state_e;
   localparam int NUM_ROWS = 16;
   localparam int NUM_F = 10;
   localparam int ROW_W = 4;
   function automatic logic [NUM_F-1:0] golden_row(input logic [NUM_ROWS*NUM_F-1:0] tbl, input logic [ROW_W-1:0] row);
      return tbl[int'(row)*NUM_F +: NUM_F];
   endfunction
endpackage

// File: rtl/tt_settle_timer.sv
// tt_settle_timer: 8-bit loadable down-counter; expire flags the last settle cycle (count==1).
module tt_settle_timer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       en,
   input  logic [7:0] load_val,
   output logic       expire
);
   logic [7:0] cnt_q, cnt_d;
   always_comb cnt_d = load ? load_val : (en && cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
   assign expire = cnt_q == 8'd1;
endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives the 16 input rows, samples F after a settle window,
// compares against GOLDEN and hands each captured row to a logger via valid/ready.
module truth_table_sweeper
   import tt_sweep_pkg::*;
#(
   parameter int SETTLE_CYCLES = 3,
   parameter logic [NUM_ROWS*NUM_F-1:0] GOLDEN = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             w,
   output logic             x,
   output logic             y,
   output logic             z,
   input  logic [NUM_F-1:0] f,
   output logic             row_valid,
   input  logic             row_ready,
   output logic [ROW_W-1:0] row_idx,
   output logic [NUM_F-1:0] row_f,
   output logic             row_mismatch,
   output logic             busy,
   output logic             done,
   output logic [4:0]       err_count,
   output logic [NUM_ROWS-1:0] fail_mask
);
   state_e state_q, state_d;
   logic [ROW_W-1:0] row_q, row_d, row_idx_q, row_idx_d;
   logic [NUM_F-1:0] row_f_q, row_f_d;
   logic row_valid_q, row_valid_d, row_mismatch_q, row_mismatch_d;
   logic [4:0] err_q, err_d;
   logic [NUM_ROWS-1:0] mask_q, mask_d;
   logic t_load, t_en, t_expire, miss;

   tt_settle_timer u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (t_load),
      .en       (t_en),
      .load_val (8'(SETTLE_CYCLES)),
      .expire   (t_expire)
   );

   always_comb begin
      state_d = state_q;
      row_d = row_q;
      row_idx_d = row_idx_q;
      row_f_d = row_f_q;
      row_valid_d = row_valid_q;
      row_mismatch_d = row_mismatch_q;
      err_d = err_q;
      mask_d = mask_q;
      t_load = 1'b0;
      t_en = 1'b0;
      miss = f != golden_row(GOLDEN, row_q);
      case (state_q)
         IDLE, DONE: if (start) begin
            state_d = SETTLE;
            row_d = '0;
            err_d = '0;
            mask_d = '0;
            t_load = 1'b1;
         end
         SETTLE: begin
            t_en = 1'b1;
            if (t_expire) begin
               state_d = REPORT;
               row_valid_d = 1'b1;
               row_f_d = f;
               row_idx_d = row_q;
               row_mismatch_d = miss;
               err_d = err_q + 5'(miss);
               mask_d[row_q] = mask_q[row_q] | miss;
            end
         end
         REPORT: if (row_ready) begin
            row_valid_d = 1'b0;
            // Last row ends the sweep before the increment so the row counter never wraps.
            if (row_q == ROW_W'(NUM_ROWS - 1)) state_d = DONE;
            else begin
               state_d = SETTLE;
               row_d = row_q + 1'b1;
               t_load = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         row_q <= '0;
         row_idx_q <= '0;
         row_f_q <= '0;
         row_valid_q <= 1'b0;
         row_mismatch_q <= 1'b0;
         err_q <= '0;
         mask_q <= '0;
      end else begin
         state_q <= state_d;
         row_q <= row_d;
         row_idx_q <= row_idx_d;
         row_f_q <= row_f_d;
         row_valid_q <= row_valid_d;
         row_mismatch_q <= row_mismatch_d;
         err_q <= err_d;
         mask_q <= mask_d;
      end

   assign {w, x, y, z} = row_q;
   assign row_valid = row_valid_q;
   assign row_idx = row_idx_q;
   assign row_f = row_f_q;
   assign row_mismatch = row_mismatch_q;
   assign busy = state_q == SETTLE || state_q == REPORT;
   assign done = state_q == DONE;
   assign err_count = err_q;
   assign fail_mask = mask_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed and randomized sweeps checked against a row-level reference model.
module tb_truth_table_sweeper;
   localparam int S = 3;
   function automatic logic [159:0] ramp();
      logic [159:0] g;
      g = '0;
      for (int r = 0; r < 16; r++) g[r*10 +: 10] = 10'(r);
      return g;
   endfunction
   localparam logic [159:0] G = ramp();

   logic clk = 1'b0;
   logic rst_n, start, row_ready, w, x, y, z, row_valid, row_mismatch, busy, done;
   logic [9:0] f, row_f, noise;
   logic [3:0] row_idx;
   logic [4:0] err_count;
   logic [15:0] fail_mask;
   logic [9:0] flip [16];
   int errors = 0, checks = 0;

   always #5 clk = ~clk;
   // Breadboard model: f echoes the row, with optional per-row faults; noise only while a row is being reported.
   assign f = {6'b0, w, x, y, z} ^ flip[{w, x, y, z}] ^ (row_valid ? noise : 10'h0);

   truth_table_sweeper #(.SETTLE_CYCLES(S), .GOLDEN(G)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .w(w), .x(x), .y(y), .z(z), .f(f),
      .row_valid(row_valid), .row_ready(row_ready), .row_idx(row_idx), .row_f(row_f),
      .row_mismatch(row_mismatch), .busy(busy), .done(done), .err_count(err_count), .fail_mask(fail_mask)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      noise = 10'($urandom);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_wxyz"}, {w, x, y, z}, 0);
      chk({tag, "_valid"}, row_valid, 0);
      chk({tag, "_idx"}, row_idx, 0);
      chk({tag, "_f"}, row_f, 0);
      chk({tag, "_mis"}, row_mismatch, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err_count, 0);
      chk({tag, "_mask"}, fail_mask, 0);
   endtask

   task automatic sweep(input int stall_row, input int stall_len, input bit rand_bp, input int poke_row);
      int r, seen, stall, cyc, exp_err;
      bit poked;
      logic [15:0] exp_mask;
      r = 0; seen = -1; stall = 0; cyc = 0; poked = 0;
      exp_err = 0; exp_mask = '0;
      for (int i = 0; i < 16; i++) if (flip[i] != 10'h0) begin
         exp_err++;
         exp_mask[i] = 1'b1;
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_busy", busy, 1);
      chk("start_done", done, 0);
      chk("start_err", err_count, 0);
      chk("start_mask", fail_mask, 0);
      chk("start_wxyz", {w, x, y, z}, 0);
      while (!done && cyc < 2000) begin
         if (r < 16) chk("wxyz", {w, x, y, z}, r);
         if (row_valid) begin
            chk("row_idx", row_idx, r);
            chk("row_f", row_f, 10'(r) ^ flip[r]);
            chk("row_mis", row_mismatch, flip[r] != 10'h0);
            if (seen != r && !rand_bp)
               chk("row_time", cyc, r * (S + 1) + S + ((stall_row >= 0 && r > stall_row) ? stall_len : 0));
            seen = r;
            if (r == stall_row && stall < stall_len) begin
               row_ready = 1'b0;
               stall++;
            end else row_ready = rand_bp ? 1'($urandom) : 1'b1;
            if (row_ready) r++;
         end else begin
            row_ready = rand_bp ? 1'($urandom) : 1'b1;
            chk("busy", busy, 1);
         end
         start = (r == poke_row && !row_valid && !poked);
         if (start) poked = 1;
         tick();
         start = 1'b0;
         cyc++;
      end
      chk("timeout", cyc < 2000, 1);
      if (!rand_bp) chk("done_time", cyc, 16 * (S + 1) + stall_len);
      chk("rows", r, 16);
      chk("end_err", err_count, exp_err);
      chk("end_mask", fail_mask, exp_mask);
      chk("end_wxyz", {w, x, y, z}, 4'hf);
      chk("end_busy", busy, 0);
      chk("end_valid", row_valid, 0);
      row_ready = 1'b1;
      tick();
      chk("done_hold", done, 1);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; row_ready = 1'b1; noise = '0;
      for (int i = 0; i < 16; i++) flip[i] = '0;
      tick();
      tick();
      chk_zero("rst");
      rst_n = 1'b1;
      tick();
      chk_zero("idle");
      sweep(-1, 0, 0, -1);
      flip[5] = 10'h200;
      sweep(-1, 0, 0, -1);
      chk("pre_restart_err", err_count, 1);
      chk("pre_restart_mask", fail_mask, 16'h0020);
      flip[5] = '0;
      sweep(-1, 0, 0, -1);
      sweep(2, 5, 0, -1);
      sweep(-1, 0, 0, 6);
      flip[2] = 10'h001;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if ({w, x, y, z} == 4'd7 && !row_valid && busy) break;
         tick();
      end
      chk("mid_row7", {w, x, y, z}, 7);
      chk("mid_err", err_count, 1);
      rst_n = 1'b0;
      #1;
      chk_zero("async_rst");
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk_zero("post_rst");
      flip[2] = '0;
      sweep(-1, 0, 0, -1);
      for (int n = 0; n < 3; n++) begin
         for (int i = 0; i < 16; i++) flip[i] = ($urandom_range(0, 3) == 0) ? 10'(1 << $urandom_range(0, 9)) : 10'h0;
         sweep(-1, 0, 1, -1);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
